// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin CPU/debug arbiter for the shared memory port with ready timeout.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          owner
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t        r_state, w_next;
    logic          r_last_owner, r_owner, r_we, r_err;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata, r_rdata;
    logic [7:0]    r_cnt;
    logic          w_grant, w_pick_dbg, w_timeout;
    assign w_grant    = cpu_req | dbg_req;
    // on a tie the requester that did not win last time gets the port
    assign w_pick_dbg = dbg_req & (~cpu_req | ~r_last_owner);
    assign w_timeout  = r_cnt == 8'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_grant ? ACCESS : IDLE;
            ACCESS:  w_next = (mem_ready || w_timeout) ? DONE : ACCESS;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_last_owner <= 1'b1;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_cnt        <= '0;
        end else if (r_state == IDLE && w_grant) begin
            r_owner      <= w_pick_dbg;
            r_last_owner <= w_pick_dbg;
            r_we         <= w_pick_dbg ? dbg_we : cpu_we;
            r_addr       <= w_pick_dbg ? dbg_addr : cpu_addr;
            r_wdata      <= w_pick_dbg ? dbg_wdata : cpu_wdata;
            r_cnt        <= '0;
        end else if (r_state == ACCESS) begin
            r_cnt <= r_cnt + 8'd1;
            if (mem_ready) begin
                r_err <= 1'b0;
                if (!r_we) r_rdata <= mem_rdata;
            end else if (w_timeout) r_err <= 1'b1;
        end
    assign busy      = r_state != IDLE;
    assign mem_read  = r_state == ACCESS && !r_we;
    assign mem_write = r_state == ACCESS && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign cpu_ack   = r_state == DONE && !r_owner;
    assign dbg_ack   = r_state == DONE && r_owner;
    assign err       = r_state == DONE && r_err;
    assign rdata     = r_rdata;
    assign owner     = r_owner;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner sequences and random transactions against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int TO = 15;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0, mem_rdata = '0;
    logic        cpu_ack, dbg_ack, err, mem_read, mem_write, busy, owner;
    logic [31:0] rdata, mem_addr, mem_wdata;
    int          total = 0, bad = 0;
    bit          m_last;
    logic [31:0] m_rdata;
    always #5 clk = ~clk;
    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
        .rdata(rdata), .err(err), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .owner(owner)
    );
    typedef struct {
        bit rb, creq, dreq, cwe, dwe;
        logic [31:0] caddr, daddr, cwdata, dwdata, mrdata;
        int dly;
        bit e_owner, e_err;
        int e_lat;
        logic [31:0] e_rdata;
    } vec_t;
    vec_t tbl[11];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask
    // dly is the ACCESS cycle carrying mem_ready; 0 means memory never answers
    function automatic vec_t predict(input vec_t v);
        bit w;
        bit ok;
        v.e_owner = (v.creq && v.dreq) ? ~m_last : v.dreq;
        w = v.e_owner ? v.dwe : v.cwe;
        ok = v.dly >= 1 && v.dly <= TO;
        v.e_lat = ok ? v.dly : TO;
        v.e_err = !ok;
        if (!w && ok) m_rdata = v.mrdata;
        v.e_rdata = m_rdata;
        m_last = v.e_owner;
        return v;
    endfunction
    task automatic do_reset();
        rst = 1'b1; cpu_req = 1'b0; dbg_req = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
        m_rdata = '0;
    endtask
    task automatic run(input vec_t v);
        logic        we;
        logic [31:0] a, d;
        int          lat;
        we = v.e_owner ? v.dwe : v.cwe;
        a = v.e_owner ? v.daddr : v.caddr;
        d = v.e_owner ? v.dwdata : v.cwdata;
        @(negedge clk);
        cpu_req = v.creq; dbg_req = v.dreq; cpu_we = v.cwe; dbg_we = v.dwe;
        cpu_addr = v.caddr; dbg_addr = v.daddr; cpu_wdata = v.cwdata; dbg_wdata = v.dwdata;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        check("busy_grant", 32'(busy), 32'd1);
        check("owner", 32'(owner), 32'(v.e_owner));
        lat = 0;
        for (int i = 1; i <= TO + 2 && lat == 0; i++) begin
            @(negedge clk);
            check("strobes", 32'({mem_read, mem_write}), 32'({~we, we}));
            check("mem_addr", mem_addr, a);
            check("mem_wdata", mem_wdata, d);
            cpu_we = 1'($urandom); dbg_we = 1'($urandom);
            cpu_addr = $urandom; dbg_addr = $urandom; cpu_wdata = $urandom; dbg_wdata = $urandom;
            mem_ready = (i == v.dly); mem_rdata = v.mrdata;
            @(posedge clk); #1;
            if (cpu_ack || dbg_ack) lat = i;
        end
        check("latency", 32'(lat), 32'(v.e_lat));
        check("cpu_ack", 32'(cpu_ack), 32'(!v.e_owner));
        check("dbg_ack", 32'(dbg_ack), 32'(v.e_owner));
        check("err", 32'(err), 32'(v.e_err));
        check("rdata", rdata, v.e_rdata);
        check("strobes_done", 32'({mem_read, mem_write}), 32'd0);
        @(negedge clk);
        cpu_req = 1'b0; dbg_req = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        check("after_done", 32'({busy, cpu_ack, dbg_ack, err}), 32'd0);
        check("rdata_hold", rdata, v.e_rdata);
    endtask
    initial begin
        vec_t p;
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 1, 1'b0, 1'b0, 1, 32'hDEADBEEF};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h200, 32'h0, 32'hCAFE0000, 32'h11111111, 2, 1'b0, 1'b0, 2, 32'h11111111};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h200, 32'h0, 32'hCAFE0000, 32'h22222222, 1, 1'b1, 1'b0, 1, 32'h11111111};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h200, 32'h0, 32'hCAFE0000, 32'h33333333, 3, 1'b0, 1'b0, 3, 32'h33333333};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h200, 32'h0, 32'hCAFE0000, 32'h44444444, 1, 1'b1, 1'b0, 1, 32'h33333333};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h40, 32'h0, 32'h12345678, 32'h0, 3, 1'b1, 1'b0, 3, 32'h33333333};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 32'h0, 32'h66666666, 0, 1'b0, 1'b1, 15, 32'h33333333};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h84, 32'h0, 32'h0, 32'h0, 32'h77777777, 2, 1'b0, 1'b0, 2, 32'h77777777};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h88, 32'h0, 32'h0, 32'h88888888, 15, 1'b1, 1'b0, 15, 32'h88888888};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8C, 32'h0, 32'h0, 32'h99999999, 16, 1'b1, 1'b1, 15, 32'h88888888};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h90, 32'h94, 32'hA5A5A5A5, 32'h0, 32'hBBBBBBBB, 1, 1'b0, 1'b0, 1, 32'h88888888};
        do_reset();
        #1;
        check("reset_ctl", 32'({cpu_ack, dbg_ack, err, mem_read, mem_write, busy, owner}), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_addr", mem_addr, 32'd0);
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rb) do_reset();
            p = predict(tbl[i]);
            run(tbl[i]);
        end
        // reset in the middle of an access drops everything at once
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        @(posedge clk); #1;
        check("pre_rst", 32'({busy, mem_read}), 32'd3);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst", 32'({mem_read, mem_write, busy, cpu_ack, dbg_ack}), 32'd0);
        cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; m_last = 1'b1; m_rdata = '0;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_ack_after_rst", 32'({cpu_ack, dbg_ack, busy}), 32'd0);
        end
        p = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h30, 32'h34, 32'h0, 32'h0, 32'hABCD0123, 1, 1'b0, 1'b0, 0, 32'h0};
        p = predict(p);
        check("model_tie_after_rst", 32'(p.e_owner), 32'd0);
        run(p);
        for (int n = 0; n < 40; n++) begin
            p.rb = 1'b0;
            p.creq = 1'($urandom); p.dreq = 1'($urandom);
            if (!p.creq && !p.dreq) p.creq = 1'b1;
            p.cwe = 1'($urandom); p.dwe = 1'($urandom);
            p.caddr = $urandom; p.daddr = $urandom; p.cwdata = $urandom; p.dwdata = $urandom;
            p.mrdata = $urandom;
            p.dly = int'($urandom_range(0, TO + 2));
            p = predict(p);
            run(p);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
